// File: rtl/shift595_pkg.sv
// Shared constants and helpers for the 595-style shift/latch block.
// Direction encodings and debounce counter sizing.
package shift595_pkg;

  localparam bit DIR_TO_LSB = 1'b0;
  localparam bit DIR_TO_MSB = 1'b1;

  // Counter only needs to reach n-1; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one button.
// Emits the accepted level and a one-cycle pulse on its falling edge.
module sync_debounce
  import shift595_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          diff;
  logic          done;

  assign diff = s2 ^ level;
  assign done = diff && (cnt == LAST);

  // Synchronise, count disagreement, flip level once it has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= RESET_LEVEL;
      s2    <= RESET_LEVEL;
      level <= RESET_LEVEL;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      fall <= done & level;
      if (!diff) begin
        cnt <= '0;
      end else if (done) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_latch_595_p.sv
// 74HC595-style shift register with storage latch, OE, clear, cascade.
// Button-driven controls are synchronised and debounced internally.
module shift_latch_595_p
  import shift595_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter bit               DIR             = DIR_TO_LSB,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1,
  parameter logic [WIDTH-1:0] OFF_VALUE       = '1,
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SER,
  input  logic             SRCLK,
  input  logic             RCLK,
  input  logic             SRCLR_N,
  input  logic             OE_N,
  output logic [WIDTH-1:0] Q,
  output logic             QS
);

  logic [2:0]       m1;
  logic [2:0]       m2;
  logic             ser_s;
  logic             clr_n_s;
  logic             oe_n_s;
  logic             shift_ev;
  logic             latch_ev;
  logic             unused_srclk_lvl;
  logic             unused_rclk_lvl;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] storage;
  logic             qs_bit;

  assign ser_s   = m2[2];
  assign clr_n_s = m2[1];
  assign oe_n_s  = m2[0];

  // Plain level synchronisers for data, clear and enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m1 <= '1;
      m2 <= '1;
    end else begin
      m1 <= {SER, SRCLR_N, OE_N};
      m2 <= m1;
    end
  end

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_srclk (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (SRCLK),
    .level(unused_srclk_lvl),
    .fall (shift_ev)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_rclk (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (RCLK),
    .level(unused_rclk_lvl),
    .fall (latch_ev)
  );

  // Shifted value and cascade tap for the chosen direction.
  always_comb begin
    sr_shift = {ser_s, sr[WIDTH-1:1]};
    qs_bit   = sr[0];
    if (DIR == DIR_TO_MSB) begin
      sr_shift = {sr[WIDTH-2:0], ser_s};
      qs_bit   = sr[WIDTH-1];
    end
  end

  // Shift register: clear wins over a same-cycle shift.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr <= RESET_VALUE;
    end else if (!clr_n_s) begin
      sr <= RESET_VALUE;
    end else if (shift_ev) begin
      sr <= sr_shift;
    end
  end

  // Storage latch captures the pre-shift, pre-clear register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      storage <= RESET_VALUE;
    end else if (latch_ev) begin
      storage <= sr;
    end
  end

  // Registered outputs; QS ignores output enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q  <= OFF_VALUE;
      QS <= (DIR == DIR_TO_MSB) ? RESET_VALUE[WIDTH-1] : RESET_VALUE[0];
    end else begin
      Q  <= oe_n_s ? OFF_VALUE : storage;
      QS <= qs_bit;
    end
  end

endmodule

// File: tb/tb_shift_latch_595_p.sv
// Directed bench for shift_latch_595_p: 8-bit DIR=0 and 16-bit DIR=1.
// Both instances share control pins; expectations are hand-computed.
module tb_shift_latch_595_p;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser = 1'b1;
  logic        srclk = 1'b1;
  logic        rclk = 1'b1;
  logic        srclr_n = 1'b1;
  logic        oe_n = 1'b1;
  logic [7:0]  q8;
  logic        qs8;
  logic [15:0] q16;
  logic        qs16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_latch_595_p #(
    .WIDTH(8), .DIR(1'b0),
    .RESET_VALUE(8'hFF), .OFF_VALUE(8'hFF),
    .DEBOUNCE_CYCLES(DB)
  ) dut8 (
    .CLK(clk), .RST_N(rst_n), .SER(ser), .SRCLK(srclk),
    .RCLK(rclk), .SRCLR_N(srclr_n), .OE_N(oe_n),
    .Q(q8), .QS(qs8)
  );

  shift_latch_595_p #(
    .WIDTH(16), .DIR(1'b1),
    .RESET_VALUE(16'hFFFF), .OFF_VALUE(16'hFFFF),
    .DEBOUNCE_CYCLES(DB)
  ) dut16 (
    .CLK(clk), .RST_N(rst_n), .SER(ser), .SRCLK(srclk),
    .RCLK(rclk), .SRCLR_N(srclr_n), .OE_N(oe_n),
    .Q(q16), .QS(qs16)
  );

  typedef struct {
    logic       ser;
    logic [7:0] exp_q;
    logic       exp_qs;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_pulse(input logic b);
    ser   = b;
    srclk = 1'b0;
    negs(8);
    srclk = 1'b1;
    negs(8);
  endtask

  task automatic latch_pulse();
    rclk = 1'b0;
    negs(8);
    rclk = 1'b1;
    negs(8);
  endtask

  logic [15:0] pat;

  initial begin
    vecs[0] = '{1'b1, 8'hFF, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 1'b1};
    vecs[2] = '{1'b1, 8'hFF, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 1'b1};
    vecs[4] = '{1'b0, 8'hFF, 1'b1};
    vecs[5] = '{1'b0, 8'hFF, 1'b1};
    vecs[6] = '{1'b0, 8'hFF, 1'b1};
    vecs[7] = '{1'b0, 8'hFF, 1'b1};

    // 1. reset
    negs(3);
    chk("rst_q8", 16'(q8), 16'h00FF);
    chk("rst_qs8", 16'(qs8), 16'h1);
    chk("rst_q16", q16, 16'hFFFF);
    rst_n = 1'b1;
    negs(10);
    chk("post_rst_q8", 16'(q8), 16'h00FF);
    chk("post_rst_qs8", 16'(qs8), 16'h1);
    chk("post_rst_qs16", 16'(qs16), 16'h1);
    oe_n = 1'b0;
    negs(4);

    // 2. shift table, then timed latch
    for (int i = 0; i < 8; i++) begin
      shift_pulse(vecs[i].ser);
      chk($sformatf("shift%0d_q", i), 16'(q8), 16'(vecs[i].exp_q));
      chk($sformatf("shift%0d_qs", i), 16'(qs8), 16'(vecs[i].exp_qs));
    end
    ser  = 1'b0;
    rclk = 1'b0;
    negs(7);
    chk("latch_early", 16'(q8), 16'h00FF);
    negs(1);
    chk("latch_q", 16'(q8), 16'h0005);
    negs(7);
    rclk = 1'b1;
    negs(8);

    // 3. bounce rejection
    ser   = 1'b1;
    srclk = 1'b0;
    negs(2);
    srclk = 1'b1;
    negs(2);
    srclk = 1'b0;
    negs(3);
    srclk = 1'b1;
    negs(12);
    chk("bounce_qs", 16'(qs8), 16'h1);
    latch_pulse();
    chk("bounce_sr", 16'(q8), 16'h0005);

    // 4. output enable
    oe_n = 1'b1;
    negs(2);
    chk("oe_early", 16'(q8), 16'h0005);
    negs(1);
    chk("oe_off", 16'(q8), 16'h00FF);
    oe_n = 1'b0;
    negs(3);
    chk("oe_on", 16'(q8), 16'h0005);

    // 5. clear beats shift; storage kept
    srclr_n = 1'b0;
    negs(3);
    shift_pulse(1'b0);
    srclr_n = 1'b1;
    negs(4);
    chk("clr_keep_q", 16'(q8), 16'h0005);
    latch_pulse();
    chk("clr_latch_q", 16'(q8), 16'h00FF);

    // 6. 16-bit DIR=1 cascade
    rst_n = 1'b0;
    negs(2);
    rst_n = 1'b1;
    negs(4);
    pat = 16'hA5C3;
    for (int i = 15; i >= 0; i--) shift_pulse(pat[i]);
    latch_pulse();
    chk("cas_q16", q16, 16'hA5C3);
    for (int i = 15; i >= 0; i--) begin
      chk($sformatf("cas_qs%0d", 15 - i), 16'(qs16), 16'(pat[i]));
      shift_pulse(1'b0);
    end
    chk("cas_drain", 16'(qs16), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_latch_595_p.md
Name: shift_latch_595_p

Overview:
Parametrised serial-in, parallel-out shift register with a separate storage latch, output enable, clear and cascade output, in the 74HC595 style. Its control inputs come from asynchronous sources (push-buttons or external pins). Inside the block they are synchronised to CLK, debounced and edge-detected, so all state changes are synchronous. Q drives the 7-segment segment bus (active-low); QS chains to a further stage.

Parameters:
WIDTH, 8, number of bits in the shift register, storage latch and Q (>=2)
DIR, 0, 0 = shift toward LSB (SER enters MSB, QS = bit 0); 1 = shift toward MSB (SER enters bit 0, QS = MSB)
RESET_VALUE, all ones, value loaded into the shift register and storage latch on reset and on clear
OFF_VALUE, all ones, value driven on Q while output is disabled
DEBOUNCE_CYCLES, 500000, consecutive stable CLK cycles required to accept a level change on SRCLK/RCLK (>=1)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
SER  input  1  serial data in, asynchronous
SRCLK  input  1  shift clock (button); a shift occurs on the accepted falling edge
RCLK  input  1  storage strobe (button); the latch loads on the accepted falling edge
SRCLR_N  input  1  shift-register clear, active-low level
OE_N  input  1  output enable, active-low level
Q  output  WIDTH  parallel output (registered)
QS  output  1  serial cascade output (registered)

Behaviour:
- Reset (RST_N low, asynchronous):
  - Shift register and latch = RESET_VALUE.
  - Debounced SRCLK and RCLK levels = 1; debounce counters = 0; synchroniser flops = 1.
  - Q = OFF_VALUE (OE treated as disabled); QS = RESET_VALUE at the QS bit position.
- Synchronisation: SER, SRCLK, RCLK, SRCLR_N and OE_N each pass through a 2-flop synchroniser.
- Debounce (SRCLK and RCLK independently):
  - Counter increments each cycle the synchronised level differs from the debounced level; it resets to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level toggles and the counter clears.
  - A debounced 1->0 transition produces a one-cycle event.
- Latency: from a pin edge to the shift/latch update is 2 + DEBOUNCE_CYCLES + 1 CLK cycles.
- Shift event:
  - DIR=0: sr <= {SER_sync, sr[WIDTH-1:1]}.
  - DIR=1: sr <= {sr[WIDTH-2:0], SER_sync}.
  - SER_sync is the synchronised SER in the event cycle. SER must be held stable across the debounce window.
- Latch event: storage <= sr as it stands before any same-cycle shift.
- Same-cycle shift and latch: the latch receives the pre-shift value, i.e. it is one stage behind, as on the 74HC595 with tied clocks.
- Clear: while SRCLR_N_sync = 0, sr <= RESET_VALUE every cycle.
  - Clear overrides a same-cycle shift.
  - Storage is unaffected by clear; a latch during clear captures the pre-clear sr.
- Q: registered; Q <= OE_N_sync ? OFF_VALUE : storage. Latch-to-Q latency is 1 cycle after the storage update.
- QS: registered copy of sr[0] (DIR=0) or sr[WIDTH-1] (DIR=1). It is never gated by OE_N.
- A glitch shorter than DEBOUNCE_CYCLES produces no event. A level held indefinitely produces exactly one event.
- Reset asserted mid-debounce aborts the pending event; no event is produced on reset release.

Decomposition:
- Shared package shift595_pkg:
  - DIR_TO_LSB = 0 and DIR_TO_MSB = 1.
  - Function for the debounce counter width: clog2(DEBOUNCE_CYCLES), minimum 1.
- One sub-module, sync_debounce (params DEBOUNCE_CYCLES, RESET_LEVEL):
  - Contains the 2-flop synchroniser, counter and debounced level.
  - Outputs the level and a fall pulse.
  - Instantiated for SRCLK and RCLK. SER, SRCLR_N and OE_N use plain 2-flop synchronisers.

Test Plan:
(All cases WIDTH=8, DIR=0, DEBOUNCE_CYCLES=4 unless noted.)
1. Reset: hold RST_N low 3 cycles, inputs at 1 -> Q=8'hFF and QS=1 during and after reset; no shift on release.
2. Shift then latch:
   - Shift SER=1,0,1,0,0,0,0,0 with clean SRCLK pulses of >=6 cycles each -> Q stays 8'hFF.
   - Then an RCLK pulse -> Q=8'h05 exactly 2+4+1+1 cycles after the RCLK falling pin edge.
3. Bounce rejection: SRCLK low 2 cycles, high 2, low 3, then high -> no shift; sr unchanged; QS unchanged.
4. Output enable: with storage=8'h05, OE_N=1 -> Q=8'hFF three cycles later; OE_N=0 -> Q=8'h05; storage preserved.
5. Clear priority: SRCLR_N=0 spanning a shift event -> sr=8'hFF; Q still 8'h05; a subsequent RCLK -> Q=8'hFF.
6. Cascade and direction: WIDTH=16, DIR=1, shift 16'hA5C3 MSB-first -> RCLK gives Q=16'hA5C3; 16 further shifts of SER=0 -> QS emits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
